// File: rtl/dsp_pkg.sv
// dsp_pkg: shared opcodes, FSM states, instruction field positions and the 8x8 vedic multiplier kernel
package dsp_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_MULW} state_t;
  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_LI   = 6'h01;
  localparam logic [5:0] OP_ADD  = 6'h02;
  localparam logic [5:0] OP_SUB  = 6'h03;
  localparam logic [5:0] OP_MUL  = 6'h04;
  localparam logic [5:0] OP_MAC  = 6'h05;
  localparam logic [5:0] OP_OUT  = 6'h06;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int IMM_W  = 16;
  // Urdhva-Tiryagbhyam: column k collects every crosswise bit product x[i]&y[j] with i+j==k
  function automatic logic [15:0] urdhva8(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] r;
    logic [3:0] c;
    r = '0;
    for (int k = 0; k < 15; k++) begin
      c = '0;
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++)
          if (i + j == k) c = c + 4'(x[i] & y[j]);
      r = r + (16'(c) << k);
    end
    return r;
  endfunction
endpackage

// File: rtl/dsp_seq_core_if.sv
// dsp_seq_core_if: program-load, control and output-channel bundle of dsp_seq_core
// master drives imem_we/imem_addr/imem_wdata/start; slave drives busy/done/err/out_data/out_valid
interface dsp_seq_core_if #(
  parameter int DATA_W     = 32,
  parameter int NOUT       = 3,
  parameter int IMEM_DEPTH = 64
) ();
  localparam int AW = $clog2(IMEM_DEPTH);
  logic                   imem_we;
  logic [AW-1:0]          imem_addr;
  logic [31:0]            imem_wdata;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic [NOUT*DATA_W-1:0] out_data;
  logic [NOUT-1:0]        out_valid;
  modport master (output imem_we, imem_addr, imem_wdata, start, input busy, done, err, out_data, out_valid);
  modport slave  (input imem_we, imem_addr, imem_wdata, start, output busy, done, err, out_data, out_valid);
endinterface

// File: rtl/vedic_mul_seq.sv
// vedic_mul_seq: sequential DATA_W x DATA_W multiplier, one byte of b per cycle, low DATA_W bits of product
// go loads a/b; p is valid while mul_done is high, DATA_W/8 cycles after go; rst aborts
module vedic_mul_seq
  import dsp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] p,
  output logic              mul_done
);
  localparam int N = DATA_W / 8;
  logic [DATA_W-1:0] a_q, b_q, acc, row;
  logic [2:0] cnt;
  logic active;
  // a_q is pre-shifted by the byte position of b_q[7:0], so each row is already aligned
  always_comb begin
    row = '0;
    for (int i = 0; i < N; i++)
      row = row + (DATA_W'(urdhva8(a_q[8*i +: 8], b_q[7:0])) << (8*i));
  end
  assign p = acc + row;
  assign mul_done = active && cnt == 3'(N-1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      cnt <= '0;
      active <= 1'b0;
    end else if (go) begin
      a_q <= a;
      b_q <= b;
      acc <= '0;
      cnt <= '0;
      active <= 1'b1;
    end else if (active) begin
      acc <= p;
      a_q <= a_q << 8;
      b_q <= b_q >> 8;
      cnt <= cnt + 3'd1;
      active <= !mul_done;
    end
  end
endmodule

// File: rtl/dsp_seq_core.sv
// dsp_seq_core: tiny sequenced DSP core (LI/ADD/SUB/MUL/MAC/OUT/HALT) with NOUT output channels
// clk/rst: clock and async active-high reset; bus: program load, start/busy/done/err, output channels
module dsp_seq_core
  import dsp_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NREGS      = 16,
  parameter int IMEM_DEPTH = 64,
  parameter int NOUT       = 3
) (
  input  logic          clk,
  input  logic          rst,
  dsp_seq_core_if.slave bus
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int RW = $clog2(NREGS);
  state_t state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] ir;
  logic [DATA_W-1:0] rf [NREGS];
  logic [5:0] op;
  logic [RW-1:0] rs_i, rt_i, rd_i, wr_idx;
  logic [DATA_W-1:0] rs_v, rt_v, rd_v, li_v, alu_v, wr_val, mul_p;
  logic [15:0] ch;
  logic legal, last, step, wr_en, go, mul_done, done_d, err_set, err_clr, out_en;
  logic done_q, err_q;
  logic [NOUT*DATA_W-1:0] out_q;
  logic [NOUT-1:0] ov_q;
  always_ff @(posedge clk) begin
    if (bus.imem_we && state_q == S_IDLE) imem[bus.imem_addr] <= bus.imem_wdata;
    ir <= imem[pc_q];
  end
  assign op    = ir[OP_LSB +: 6];
  assign rs_i  = RW'(32'(ir[RS_LSB +: 5]) % NREGS);
  assign rt_i  = RW'(32'(ir[RT_LSB +: 5]) % NREGS);
  assign rd_i  = RW'(32'(ir[RD_LSB +: 5]) % NREGS);
  assign rs_v  = rf[rs_i];
  assign rt_v  = rf[rt_i];
  assign rd_v  = rf[rd_i];
  assign li_v  = DATA_W'({{16{ir[IMM_W-1]}}, ir[IMM_W-1:0]});
  assign alu_v = op == OP_SUB ? rs_v - rt_v : rs_v + rt_v;
  assign ch    = ir[IMM_W-1:0] % 16'(NOUT);
  assign legal = op <= OP_OUT || op == OP_HALT;
  assign last  = pc_q == AW'(IMEM_DEPTH-1);
  vedic_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk(clk), .rst(rst), .go(go), .a(rs_v), .b(rt_v), .p(mul_p), .mul_done(mul_done)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    step = 1'b0;
    wr_en = 1'b0;
    wr_idx = rd_i;
    wr_val = alu_v;
    out_en = 1'b0;
    go = 1'b0;
    done_d = 1'b0;
    err_set = 1'b0;
    err_clr = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start && !bus.imem_we) begin
        state_d = S_FETCH;
        pc_d = '0;
        err_clr = 1'b1;
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: if (!legal || op == OP_HALT) begin
        state_d = S_IDLE;
        done_d = 1'b1;
        err_set = !legal;
      end else if (op == OP_MUL || op == OP_MAC) begin
        go = 1'b1;
        state_d = S_MULW;
      end else begin
        wr_en = op == OP_LI || op == OP_ADD || op == OP_SUB;
        wr_idx = op == OP_LI ? rt_i : rd_i;
        wr_val = op == OP_LI ? li_v : alu_v;
        out_en = op == OP_OUT;
        step = 1'b1;
      end
      S_MULW: if (mul_done) begin
        wr_en = 1'b1;
        wr_val = op == OP_MAC ? rd_v + mul_p : mul_p;
        step = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // the last imem word completes normally, then ends the program as an overrun instead of wrapping
    if (step) begin
      state_d = last ? S_IDLE : S_FETCH;
      pc_d = last ? pc_q : pc_q + 1'b1;
      done_d = last;
      err_set = last;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      out_q <= '0;
      ov_q <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      done_q <= done_d;
      err_q <= err_clr ? 1'b0 : err_q | err_set;
      ov_q <= out_en ? NOUT'(1) << ch : '0;
      if (out_en) out_q[ch*DATA_W +: DATA_W] <= rs_v;
      if (wr_en && wr_idx != '0) rf[wr_idx] <= wr_val;
    end
  end
  assign bus.busy = state_q != S_IDLE;
  assign bus.done = done_q;
  assign bus.err = err_q;
  assign bus.out_data = out_q;
  assign bus.out_valid = ov_q;
endmodule

// File: tb/tb_dsp_seq_core.sv
// tb_dsp_seq_core: scoreboard bench for dsp_seq_core with a program-interpreter reference model
module tb_dsp_seq_core;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  dsp_seq_core_if #(.DATA_W(32), .NOUT(3), .IMEM_DEPTH(64)) ifa ();
  dsp_seq_core_if #(.DATA_W(32), .NOUT(3), .IMEM_DEPTH(4)) ifb ();
  dsp_seq_core #(.DATA_W(32), .NREGS(16), .IMEM_DEPTH(64), .NOUT(3)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  dsp_seq_core #(.DATA_W(32), .NREGS(16), .IMEM_DEPTH(4), .NOUT(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  typedef struct packed { logic [2:0] valid; logic [95:0] data; logic [31:0] due; } oev_t;
  typedef struct packed { logic err; logic [31:0] due; } dev_t;
  oev_t oq0[$], oq1[$];
  dev_t dq0[$], dq1[$];
  int total = 0, bad = 0, cycle = 0, last_c0 = 0;
  logic [31:0] mem [2][64];
  logic [31:0] rf [2][16];
  logic [31:0] outs [2][3];
  logic [31:0] prog[$];
  always @(posedge clk) cycle <= cycle + 1;
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] ins(input int op, input int rs, input int rt, input int rd);
    return {6'(op), 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction
  function automatic logic [31:0] insi(input int op, input int rs, input int rt, input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) rf[d][i] = 0;
      for (int i = 0; i < 3; i++) outs[d][i] = 0;
    end
    oq0.delete(); oq1.delete(); dq0.delete(); dq1.delete();
  endtask
  task automatic wr(input int d, input int r, input logic [31:0] v);
    if (r != 0) rf[d][r] = v;
  endtask
  task automatic push_done(input int d, input logic e, input int due);
    dev_t x;
    x.err = e;
    x.due = due;
    if (d == 0) dq0.push_back(x); else dq1.push_back(x);
  endtask
  // interprets the program word by word; every instruction costs 2 clocks, 6 for MUL/MAC
  task automatic run_model(input int d, input int c0);
    int pc, t, rs, rt, rd, lat, ch, dep;
    logic [31:0] w, a, b;
    logic [5:0] op;
    oev_t oe;
    dep = d ? 4 : 64;
    pc = 0;
    t = c0;
    forever begin
      w = mem[d][pc];
      op = w[31:26];
      rs = int'(w[25:21]) % 16;
      rt = int'(w[20:16]) % 16;
      rd = int'(w[15:11]) % 16;
      a = rf[d][rs];
      b = rf[d][rt];
      lat = 2;
      if (op == 6'h3F || op > 6'h06) begin
        push_done(d, op != 6'h3F, t + 2);
        return;
      end
      if (op == 1) wr(d, rt, {{16{w[15]}}, w[15:0]});
      else if (op == 2) wr(d, rd, a + b);
      else if (op == 3) wr(d, rd, a - b);
      else if (op == 4) begin lat = 6; wr(d, rd, a * b); end
      else if (op == 5) begin lat = 6; wr(d, rd, rf[d][rd] + a * b); end
      else if (op == 6) begin
        ch = int'(w[15:0]) % 3;
        outs[d][ch] = a;
        oe.valid = 3'(1 << ch);
        oe.data = {outs[d][2], outs[d][1], outs[d][0]};
        oe.due = t + 2;
        if (d == 0) oq0.push_back(oe); else oq1.push_back(oe);
      end
      t += lat;
      if (pc == dep - 1) begin
        push_done(d, 1'b1, t);
        return;
      end
      pc++;
    end
  endtask
  logic [2:0] m_ov;
  logic [95:0] m_od;
  logic m_dn, m_er;
  oev_t m_oe;
  dev_t m_de;
  always @(negedge clk) begin
    if (!rst) for (int d = 0; d < 2; d++) begin
      m_ov = d ? ifb.out_valid : ifa.out_valid;
      m_od = d ? ifb.out_data : ifa.out_data;
      m_dn = d ? ifb.done : ifa.done;
      m_er = d ? ifb.err : ifa.err;
      if (m_ov != 0) begin
        if ((d == 0 ? oq0.size() : oq1.size()) == 0) begin
          total++;
          bad++;
          $display("FAIL out_unexpected dut%0d: got valid %b want none", d, m_ov);
        end else begin
          if (d == 0) m_oe = oq0.pop_front(); else m_oe = oq1.pop_front();
          chk($sformatf("out_valid dut%0d", d), 96'(m_ov), 96'(m_oe.valid));
          chk($sformatf("out_data dut%0d", d), m_od, m_oe.data);
          chk($sformatf("out_cycle dut%0d", d), 96'(cycle), 96'(m_oe.due));
        end
      end
      if (m_dn) begin
        if ((d == 0 ? dq0.size() : dq1.size()) == 0) begin
          total++;
          bad++;
          $display("FAIL done_unexpected dut%0d: got done want none", d);
        end else begin
          if (d == 0) m_de = dq0.pop_front(); else m_de = dq1.pop_front();
          chk($sformatf("done_err dut%0d", d), 96'(m_er), 96'(m_de.err));
          chk($sformatf("done_cycle dut%0d", d), 96'(cycle), 96'(m_de.due));
        end
      end
    end
  end
  task automatic load(input int d);
    foreach (prog[i]) begin
      @(negedge clk);
      if (d == 0) begin ifa.imem_we = 1; ifa.imem_addr = 6'(i); ifa.imem_wdata = prog[i]; end
      else begin ifb.imem_we = 1; ifb.imem_addr = 2'(i); ifb.imem_wdata = prog[i]; end
      mem[d][i] = prog[i];
    end
    @(negedge clk);
    ifa.imem_we = 0;
    ifb.imem_we = 0;
  endtask
  task automatic start_prog(input int d);
    @(negedge clk);
    if (d == 0) ifa.start = 1; else ifb.start = 1;
    @(posedge clk);
    #1;
    ifa.start = 0;
    ifb.start = 0;
    last_c0 = cycle;
    run_model(d, cycle);
    chk($sformatf("busy_after_start dut%0d", d), 96'(d ? ifb.busy : ifa.busy), 96'(1));
  endtask
  task automatic wait_done(input int d);
    int n = 0;
    while ((d == 0 ? dq0.size() : dq1.size()) != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if ((d == 0 ? dq0.size() : dq1.size()) != 0) begin
      total++;
      bad++;
      $display("FAIL timeout dut%0d: got no done after %0d cycles, want done", d, n);
      if (d == 0) begin dq0.delete(); oq0.delete(); end else begin dq1.delete(); oq1.delete(); end
    end
    @(negedge clk);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 96'(ifa.busy), 0);
    chk({tag, "_done"}, 96'(ifa.done), 0);
    chk({tag, "_err"}, 96'(ifa.err), 0);
    chk({tag, "_out_data"}, ifa.out_data, 0);
    chk({tag, "_out_valid"}, 96'(ifa.out_valid), 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end
  initial begin
    int n, k, r1, r2, r3;
    {ifa.imem_we, ifa.start, ifb.imem_we, ifb.start} = '0;
    ifa.imem_addr = 0; ifa.imem_wdata = 0; ifb.imem_addr = 0; ifb.imem_wdata = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 0;
    prog = '{insi(1, 0, 1, 5), insi(1, 0, 2, 7), ins(2, 1, 2, 3), insi(6, 3, 0, 0), ins(63, 0, 0, 0)};
    load(0); start_prog(0); wait_done(0);
    chk("add_ch0", 96'(ifa.out_data[31:0]), 96'(12));
    chk("add_err", 96'(ifa.err), 0);
    prog = '{insi(1, 0, 1, 16'hFFFD), insi(1, 0, 2, 1000), ins(4, 1, 2, 4), insi(6, 4, 0, 2), ins(63, 0, 0, 0)};
    load(0); start_prog(0); wait_done(0);
    chk("mul_ch2", 96'(ifa.out_data[95:64]), 96'(32'hFFFFF448));
    prog = '{insi(1, 0, 5, 10), insi(1, 0, 1, 4), insi(1, 0, 2, 4), ins(5, 1, 2, 5), ins(5, 1, 2, 5),
             ins(5, 1, 2, 5), insi(6, 5, 0, 1), ins(63, 0, 0, 0)};
    load(0); start_prog(0); wait_done(0);
    chk("mac_ch1", 96'(ifa.out_data[63:32]), 96'(58));
    prog = '{insi(1, 0, 1, 1), ins(6'h2A, 1, 2, 3), insi(1, 0, 1, 99), insi(6, 1, 0, 0), ins(63, 0, 0, 0)};
    load(0); start_prog(0); wait_done(0);
    chk("illegal_err_sticky", 96'(ifa.err), 96'(1));
    prog = '{insi(1, 0, 1, 5), insi(1, 0, 2, 7), ins(2, 1, 2, 3), insi(6, 3, 0, 0), ins(63, 0, 0, 0)};
    load(0); start_prog(0);
    chk("start_clears_err", 96'(ifa.err), 0);
    wait_done(0);
    @(negedge clk);
    ifa.imem_we = 1; ifa.imem_addr = 6'd63; ifa.imem_wdata = 0; ifa.start = 1;
    mem[0][63] = 0;
    @(posedge clk);
    #1;
    chk("we_over_start_busy", 96'(ifa.busy), 0);
    ifa.imem_we = 0;
    ifa.start = 0;
    prog = '{insi(1, 0, 1, 9), insi(1, 0, 2, 3), ins(2, 1, 2, 3), insi(6, 3, 0, 1)};
    load(1); start_prog(1);
    @(negedge clk); ifb.start = 1;
    @(negedge clk); ifb.start = 0; ifb.imem_we = 1; ifb.imem_addr = 2'd3; ifb.imem_wdata = ins(63, 0, 0, 0);
    @(negedge clk); ifb.imem_we = 0;
    wait_done(1);
    chk("overrun_err", 96'(ifb.err), 96'(1));
    start_prog(1); wait_done(1);
    chk("overrun_rerun_ch1", 96'(ifb.out_data[63:32]), 96'(12));
    for (int p = 0; p < 15; p++) begin
      prog.delete();
      n = $urandom_range(4, 14);
      for (int i = 0; i < n; i++) begin
        k = $urandom_range(0, 7);
        r1 = $urandom_range(0, 31); r2 = $urandom_range(0, 31); r3 = $urandom_range(0, 31);
        case (k)
          0, 1: prog.push_back(insi(1, 0, r2, 16'($urandom)));
          2: prog.push_back(ins(2, r1, r2, r3));
          3: prog.push_back(ins(3, r1, r2, r3));
          4: prog.push_back(ins(4, r1, r2, r3));
          5: prog.push_back(ins(5, r1, r2, r3));
          6: prog.push_back(insi(6, r1, 0, 16'($urandom_range(0, 7))));
          default: prog.push_back(ins(0, r1, r2, r3));
        endcase
      end
      if ($urandom_range(0, 4) == 0) prog[$urandom_range(0, n - 1)] = ins($urandom_range(7, 62), 1, 2, 3);
      prog.push_back(ins(63, 0, 0, 0));
      load(0); start_prog(0); wait_done(0);
    end
    prog = '{insi(1, 0, 1, 16'hFFFD), insi(1, 0, 2, 1000), ins(4, 1, 2, 4), insi(6, 4, 0, 2), ins(63, 0, 0, 0)};
    load(0); start_prog(0);
    while (cycle < last_c0 + 7) @(negedge clk);
    rst = 1;
    #1;
    chk_zero("rst_mulw");
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 0;
    start_prog(0); wait_done(0);
    chk("rerun_mul_ch2", 96'(ifa.out_data[95:64]), 96'(32'hFFFFF448));
    repeat (3) @(negedge clk);
    chk("pending_events", 96'(oq0.size() + oq1.size() + dq0.size() + dq1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
